// File: rtl/cam_capture.sv
// -----------------------------------------------------------------------------
// cam_capture
//
// Camera pixel capture stage in the camera PCLK domain. It turns the OV7670
// RGB444 byte stream (VSYNC/HREF/D) into 12-bit pixels with a valid strobe.
// Capture starts only on a frame boundary (VSYNC falling edge). Each frame is
// clamped to H_ACTIVE x V_ACTIVE pixels, so a downstream linear write address
// stays aligned with the frame.
//
// Optional feature macro: CAM_CAPTURE_TESTPATTERN_EN
//   When defined, o_data carries the in-line pixel index instead of the camera
//   data. Timing, clamping, strobes and error reporting are unchanged.
//
// Ports:
//   i_clk         camera PCLK; all logic runs on the rising edge
//   i_rstn        synchronous active-low reset
//   i_en          capture enable (level); sampled only at frame boundaries
//   i_vsync       camera VSYNC, high = vertical blanking
//   i_href        camera HREF, high = active line bytes
//   i_data        camera data byte
//   o_valid       one-cycle pixel strobe
//   o_data        pixel {R[3:0],G[3:0],B[3:0]}
//   o_sof         high with o_valid on the first pixel of a frame
//   o_frame_done  one-cycle pulse at the end of a captured frame
//   o_frame_err   size error of the last completed frame; held until next done
// -----------------------------------------------------------------------------
module cam_capture #(
  parameter int DATA_WIDTH = 12,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic                  i_vsync,
  input  logic                  i_href,
  input  logic [7:0]            i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sof,
  output logic                  o_frame_done,
  output logic                  o_frame_err
);

  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);

  localparam logic [PW-1:0] H_MAX    = PW'(H_ACTIVE);
  localparam logic [LW-1:0] V_MAX    = LW'(V_ACTIVE);
  localparam logic [PW-1:0] PIX_SAT  = '1;
  localparam logic [LW-1:0] LINE_SAT = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_ACTIVE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Input stage S1 plus the previous S1 value for edge detection
  logic       vs1_q, hr1_q;
  logic [7:0] d1_q;
  logic       vs_prev_q, hr_prev_q;

  logic            phase_q, phase_d;
  logic [3:0]      r_q, r_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]   line_cnt_q, line_cnt_d;
  logic            line_err_q, line_err_d;
  logic            sof_pend_q, sof_pend_d;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sof_q, sof_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic vs_rise, vs_fall, href_fall;
  logic [DATA_WIDTH-1:0] pix_word;

  assign vs_rise   =  vs1_q & ~vs_prev_q;
  assign vs_fall   = ~vs1_q &  vs_prev_q;
  assign href_fall =  hr_prev_q & ~hr1_q;

`ifdef CAM_CAPTURE_TESTPATTERN_EN
  assign pix_word = DATA_WIDTH'(pix_cnt_q);
`else
  assign pix_word = DATA_WIDTH'({r_q, d1_q});
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      vs1_q      <= 1'b0;
      hr1_q      <= 1'b0;
      d1_q       <= 8'd0;
      vs_prev_q  <= 1'b0;
      hr_prev_q  <= 1'b0;
      phase_q    <= 1'b0;
      r_q        <= 4'd0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      line_err_q <= 1'b0;
      sof_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sof_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs1_q      <= i_vsync;
      hr1_q      <= i_href;
      d1_q       <= i_data;
      vs_prev_q  <= vs1_q;
      hr_prev_q  <= hr1_q;
      phase_q    <= phase_d;
      r_q        <= r_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      line_err_q <= line_err_d;
      sof_pend_q <= sof_pend_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sof_q      <= sof_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    r_d        = r_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    line_err_d = line_err_q;
    sof_pend_d = sof_pend_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    sof_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (i_en) state_d = S_WAIT_SOF;
      end

      S_WAIT_SOF: begin
        if (!i_en) begin
          // No frame in flight yet, so disabling takes effect immediately
          state_d = S_IDLE;
        end else if (vs_fall) begin
          state_d    = S_ACTIVE;
          phase_d    = 1'b0;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          line_err_d = 1'b0;
          sof_pend_d = 1'b1;
        end
      end

      S_ACTIVE: begin
        if (hr1_q) begin
          if (!phase_q) begin
            r_d     = d1_q[3:0];
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((pix_cnt_q < H_MAX) && (line_cnt_q < V_MAX)) begin
              valid_d    = 1'b1;
              data_d     = pix_word;
              sof_d      = sof_pend_q;
              sof_pend_d = 1'b0;
            end
            // A pixel beyond H_ACTIVE already makes the line too long; flag
            // it here so a saturated counter can never alias back to H_ACTIVE
            if (pix_cnt_q == H_MAX) line_err_d = 1'b1;
            if (pix_cnt_q != PIX_SAT) pix_cnt_d = pix_cnt_q + PW'(1);
          end
        end

        // href is low here, so this never collides with a capture above.
        // A trailing odd byte is dropped by clearing the phase.
        if (href_fall) begin
          phase_d   = 1'b0;
          pix_cnt_d = '0;
          if (pix_cnt_q != H_MAX) line_err_d = 1'b1;
          if (line_cnt_q != LINE_SAT) line_cnt_d = line_cnt_q + LW'(1);
        end

        // Uses the _d values so a line ending on this same cycle is counted
        if (vs_rise) begin
          done_d  = 1'b1;
          err_d   = (line_cnt_d != V_MAX) | line_err_d;
          state_d = i_en ? S_WAIT_SOF : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_sof        = sof_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;

endmodule
